stw_sequencer: RTL and testbench

STW_SEQUENCER -- requirements
Module: stw_sequencer

---
 rtl/stw_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_stw_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_sequencer.sv
// Self-test sweep sequencer: broadcasts four ROM vectors to the PE array and
// collects per-PE pass/fail into a sticky bypass map. Optional STW_TIMEOUT_EN bounds WAIT.
module stw_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int NUM_PE         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  output logic                 STW_test_load_en,
  output logic [WORD_SIZE-1:0] STW_mult_op1,
  output logic [WORD_SIZE-1:0] STW_mult_op2,
  output logic [WORD_SIZE-1:0] STW_add_op,
  output logic [WORD_SIZE-1:0] STW_expected,
  output logic                 STW_start,
  input  logic [NUM_PE-1:0]    STW_complete_in,
  input  logic [NUM_PE-1:0]    STW_result_in,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PE-1:0]    fail_map,
  output logic                 stw_timeout
);

  // state | meaning
  // IDLE  | waiting for test_req
  // LOAD  | vector vidx on operand bus, load strobe high
  // START | start strobe high
  // WAIT  | waiting for all PEs to complete (first cycle ignores complete)
  // CHECK | merge PE results into fail_map, advance vidx
  // DONE  | one-cycle done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

`ifdef STW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  localparam int CNT_W = 1;
`endif

  logic [2:0]           state_q, state_d;
  logic [1:0]           vidx_q, vidx_d;
  logic [NUM_PE-1:0]    fail_map_q, fail_map_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [WORD_SIZE-1:0] rom_op1, rom_op2, rom_add, rom_exp;

`ifdef STW_TIMEOUT_EN
  logic stw_timeout_q, stw_timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Expected words are (op1*op2+add) mod 2^16, precomputed for the default width.
  always_comb begin
    rom_op1 = '0;
    rom_op2 = '0;
    rom_add = '0;
    rom_exp = '0;
    case (vidx_q)
      2'd0: begin
        rom_op1 = WORD_SIZE'(16'h0003);
        rom_op2 = WORD_SIZE'(16'h0005);
        rom_add = WORD_SIZE'(16'h0007);
        rom_exp = WORD_SIZE'(16'h0016);
      end
      2'd1: begin
        rom_op1 = WORD_SIZE'(16'hFFFF);
        rom_op2 = WORD_SIZE'(16'h0001);
        rom_add = WORD_SIZE'(16'h0001);
        rom_exp = WORD_SIZE'(16'h0000);
      end
      2'd2: begin
        rom_op1 = WORD_SIZE'(16'h00FF);
        rom_op2 = WORD_SIZE'(16'h0100);
        rom_add = WORD_SIZE'(16'h0000);
        rom_exp = WORD_SIZE'(16'hFF00);
      end
      default: begin
        rom_op1 = WORD_SIZE'(16'h5555);
        rom_op2 = WORD_SIZE'(16'h0002);
        rom_add = WORD_SIZE'(16'hAAAA);
        rom_exp = WORD_SIZE'(16'h5554);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    vidx_d     = vidx_q;
    fail_map_d = fail_map_q;
    wait_cnt_d = wait_cnt_q;
`ifdef STW_TIMEOUT_EN
    stw_timeout_d = stw_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (test_req) begin
          fail_map_d = '0;
          vidx_d     = '0;
`ifdef STW_TIMEOUT_EN
          stw_timeout_d = 1'b0;
`endif
          state_d    = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
`ifdef STW_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
`else
        wait_cnt_d = 1'b1;
`endif
        // A zero count marks the first WAIT cycle, where complete may be stale.
        if ((wait_cnt_q != '0) && (&STW_complete_in)) begin
          state_d = S_CHECK;
        end
`ifdef STW_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Non-completers are marked here; CHECK then adds the ~result term.
          fail_map_d    = fail_map_q | ~STW_complete_in;
          stw_timeout_d = 1'b1;
          state_d       = S_CHECK;
        end
`endif
      end
      S_CHECK: begin
        fail_map_d = fail_map_q | ~STW_result_in;
        if (vidx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          vidx_d  = vidx_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vidx_q     <= '0;
      fail_map_q <= '0;
      wait_cnt_q <= '0;
`ifdef STW_TIMEOUT_EN
      stw_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vidx_q     <= vidx_d;
      fail_map_q <= fail_map_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef STW_TIMEOUT_EN
      stw_timeout_q <= stw_timeout_d;
`endif
    end
  end

  assign STW_test_load_en = (state_q == S_LOAD);
  assign STW_mult_op1     = STW_test_load_en ? rom_op1 : '0;
  assign STW_mult_op2     = STW_test_load_en ? rom_op2 : '0;
  assign STW_add_op       = STW_test_load_en ? rom_add : '0;
  assign STW_expected     = STW_test_load_en ? rom_exp : '0;
  assign STW_start        = (state_q == S_START);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign fail_map         = fail_map_q;
`ifdef STW_TIMEOUT_EN
  assign stw_timeout      = stw_timeout_q;
`else
  assign stw_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_stw_sequencer.sv
// Randomized bench for stw_sequencer: PE array model plus sweep-level reference
// for vector order, sweep length, fail_map and timeout flag.
module tb_stw_sequencer;
  localparam int WS    = 16;
  localparam int NPE   = 4;
  localparam int TMO   = 12;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            test_req = 1'b0;
  logic            load_en, start_o, busy, done, stw_timeout;
  logic [WS-1:0]   op1, op2, add_op, exp_o;
  logic [NPE-1:0]  complete_in = '0, result_in = '0, fail_map;

  stw_sequencer #(.WORD_SIZE(WS), .NUM_PE(NPE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .test_req(test_req),
    .STW_test_load_en(load_en),
    .STW_mult_op1(op1), .STW_mult_op2(op2), .STW_add_op(add_op), .STW_expected(exp_o),
    .STW_start(start_o),
    .STW_complete_in(complete_in), .STW_result_in(result_in),
    .busy(busy), .done(done), .fail_map(fail_map), .stw_timeout(stw_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] op1_tab [4] = '{16'h0003, 16'hFFFF, 16'h00FF, 16'h5555};
  logic [15:0] op2_tab [4] = '{16'h0005, 16'h0001, 16'h0100, 16'h0002};
  logic [15:0] add_tab [4] = '{16'h0007, 16'h0001, 16'h0000, 16'hAAAA};

  function automatic logic [15:0] exp_of(input int v);
    logic [31:0] p;
    p = 32'(op1_tab[v]) * 32'(op2_tab[v]) + 32'(add_tab[v]);
    return p[15:0];
  endfunction

  // Per-vector PE behaviour: completion latency after start, pass bit, stale complete.
  int lat  [4][NPE];
  bit pass [4][NPE];
  bit stale[4];

  int loads_seen = 0;
  int done_cnt   = 0;
  bit started    = 0;
  int since      = 0;

  // One cycle: observe outputs at negedge, then drive PE responses for this cycle.
  task automatic tick();
    int v;
    logic [NPE-1:0] c, r;
    @(negedge clk);
    if (load_en) begin
      if (loads_seen < 4)
        check_val($sformatf("vec%0d", loads_seen), {op1, op2, add_op, exp_o},
                  {op1_tab[loads_seen], op2_tab[loads_seen], add_tab[loads_seen], exp_of(loads_seen)});
      loads_seen++;
      started = 0;
    end else begin
      check_val("ops_idle", {op1, op2, add_op, exp_o}, 64'h0);
    end
    if (done) done_cnt++;
    if (start_o) begin
      started = 1;
      since   = 0;
    end else if (started) begin
      since++;
    end
    v = (loads_seen == 0) ? 0 : ((loads_seen > 4) ? 3 : loads_seen - 1);
    for (int i = 0; i < NPE; i++) begin
      c[i] = (loads_seen > 0) && (stale[v] || (started && since >= lat[v][i]));
      r[i] = c[i] ? pass[v][i] : 1'($urandom_range(0, 1));
    end
    complete_in = c;
    result_in   = r;
  endtask

  task automatic set_uniform(input int l);
    for (int v = 0; v < 4; v++) begin
      stale[v] = 0;
      for (int i = 0; i < NPE; i++) begin
        lat[v][i]  = l;
        pass[v][i] = 1;
      end
    end
  endtask

  task automatic gen_random();
    for (int v = 0; v < 4; v++) begin
      stale[v] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NPE; i++) begin
        lat[v][i]  = $urandom_range(1, 6);
        pass[v][i] = ($urandom_range(0, 7) != 0);
      end
    end
  endtask

  task automatic run_sweep(input string tag, input bit poke);
    int total, n, w, maxlat;
    logic [NPE-1:0] fmap;
    bit tmo;
    total = 1;
    fmap  = '0;
    tmo   = 0;
    for (int v = 0; v < 4; v++) begin
      maxlat = 0;
      for (int i = 0; i < NPE; i++) begin
        if (lat[v][i] > maxlat) maxlat = lat[v][i];
        if (!pass[v][i]) fmap[i] = 1'b1;
      end
      if (stale[v]) w = 2;
`ifdef STW_TIMEOUT_EN
      else if (maxlat > TMO) begin
        w   = TMO;
        tmo = 1;
        for (int i = 0; i < NPE; i++) if (lat[v][i] > TMO) fmap[i] = 1'b1;
      end
`endif
      else w = (maxlat < 2) ? 2 : maxlat;
      total += 3 + w;
    end
    loads_seen = 0;
    done_cnt   = 0;
    started    = 0;
    n          = 0;
    test_req   = 1;
    while (done_cnt == 0 && n < total + 20) begin
      tick();
      n++;
      test_req = poke && ($urandom_range(0, 3) == 0);
    end
    test_req = 0;
    check_val({tag, "_len"}, 64'(n), 64'(total));
    check_val({tag, "_loads"}, 64'(loads_seen), 64'd4);
    check_val({tag, "_fail_map"}, 64'(fail_map), 64'(fmap));
    check_val({tag, "_timeout"}, 64'(stw_timeout), 64'(tmo));
    repeat (3) tick();
    check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_fail_hold"}, 64'(fail_map), 64'(fmap));
  endtask

  initial begin
    int n;
    set_uniform(3);
    rst = 1;
    repeat (2) tick();
    check_val("rst_outputs", {load_en, start_o, busy, done, stw_timeout, fail_map}, 64'h0);
    rst = 0;
    tick();

    // rst wins over test_req in the same cycle
    rst = 1;
    test_req = 1;
    tick();
    check_val("rst_prio_busy", 64'(busy), 64'd0);
    rst = 0;
    test_req = 0;
    tick();

    set_uniform(3);
    run_sweep("all_pass", 0);

    set_uniform(3);
    pass[1][2] = 0;
    run_sweep("pe2_v1", 0);
    repeat (5) tick();
    check_val("pe2_hold", 64'(fail_map), 64'h4);

    set_uniform(3);
    for (int v = 0; v < 4; v++) stale[v] = 1;
    run_sweep("stale", 1);

    // reset during WAIT of v2
    set_uniform(4);
    pass[0][1] = 0;
    loads_seen = 0;
    done_cnt = 0;
    started = 0;
    n = 0;
    test_req = 1;
    while (!(loads_seen == 3 && started && since == 1) && n < 200) begin
      tick();
      n++;
      test_req = 0;
    end
    check_val("rst_reach_wait", 64'(loads_seen == 3 && started && since == 1), 64'd1);
    check_val("pre_rst_fail", 64'(fail_map), 64'h2);
    rst = 1;
    tick();
    check_val("mid_rst_state", {load_en, start_o, busy, done, stw_timeout, fail_map}, 64'h0);
    check_val("mid_rst_nodone", 64'(done_cnt), 64'd0);
    rst = 0;
    tick();
    set_uniform(3);
    run_sweep("after_rst", 1);

    // PE3 never completes
    for (int v = 0; v < 4; v++) begin
      stale[v] = 0;
      for (int i = 0; i < NPE; i++) begin
        lat[v][i]  = (i == 3) ? NEVER : $urandom_range(2, 5);
        pass[v][i] = 1;
      end
    end
`ifdef STW_TIMEOUT_EN
    run_sweep("pe3_tmo", 1);
`else
    loads_seen = 0;
    done_cnt = 0;
    started = 0;
    test_req = 1;
    tick();
    test_req = 0;
    repeat (150) tick();
    check_val("hang_busy", 64'(busy), 64'd1);
    check_val("hang_nodone", 64'(done_cnt), 64'd0);
    check_val("hang_loads", 64'(loads_seen), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    tick();
`endif

    for (int k = 0; k < 20; k++) begin
      gen_random();
      run_sweep($sformatf("rnd%0d", k), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
